// File: rtl/lpc_autocorr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_pkg
//  Purpose  : Shared definitions for the lpc_autocorr frame autocorrelation
//             engine: Avalon-MM register addresses, CTRL bit positions,
//             reset values, result slice count and the MAC sequencer states.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lpc_pkg;

    // Each accumulator is exposed as this many 16-bit slices.
    localparam int SLICES = 3;

    // Register map (word addresses).
    localparam logic [15:0] ADDR_FRAME_LEN   = 16'h0000;
    localparam logic [15:0] ADDR_CTRL        = 16'h0001;
    localparam logic [15:0] ADDR_RESULT_BASE = 16'h0010;

    // CTRL bit positions.
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_READY_BIT   = 1;
    localparam int CTRL_OVERRUN_BIT = 2;

    // Frame length after reset (classic 30 ms @ 8 kHz encoder frame).
    localparam int FRAME_LEN_RESET = 240;

    // MAC sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_CHK    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lpc_autocorr_if.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_autocorr_if
//  Purpose  : Groups the sample stream and the Avalon-MM slave bus of the
//             autocorrelation engine.
//  Signals  : x/v        - signed sample and its one-cycle strobe
//             address    - Avalon word address
//             read/write - Avalon strobes
//             writedata  - Avalon write data
//             readdata   - Avalon read data (1-cycle latency, registered)
//  Modports : master (sample source / bus host), slave (engine)
//  Revision : 1.0 - initial release
// ============================================================================
interface lpc_autocorr_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] x;
    logic                     v;
    logic [15:0]              address;
    logic                     read;
    logic                     write;
    logic [15:0]              writedata;
    logic [15:0]              readdata;

    modport master (
        output x, v, address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  x, v, address, read, write, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/lpc_autocorr_preemph.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_preemph
//  Purpose  : First-order pre-emphasis y = x - ((31*x_prev) >>> 5),
//             saturated to DATA_W. x_prev is the last accepted raw sample;
//             it is held across frames and cleared by clr.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-low reset
//             clr  - clear the stored previous sample
//             load - current x is being accepted; store it as x_prev
//             x    - raw signed sample
//             y    - filtered, saturated sample (combinational from x)
//  Revision : 1.0 - initial release
// ============================================================================
module lpc_preemph #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);
    // Headroom for 31*x_prev and the subtraction.
    localparam int EXT_W = DATA_W + 6;

    logic signed [DATA_W-1:0] prev;
    logic signed [EXT_W-1:0]  prev_ext;
    logic signed [EXT_W-1:0]  x_ext;
    logic signed [EXT_W-1:0]  scaled;
    logic signed [EXT_W-1:0]  diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (clr) begin
            prev <= '0;
        end else if (load) begin
            prev <= x;
        end
    end

    always_comb begin
        prev_ext = EXT_W'(prev);
        x_ext    = EXT_W'(x);
        // 31*p computed as 32*p - p, then an arithmetic (floor) shift.
        scaled   = ((prev_ext <<< 5) - prev_ext) >>> 5;
        diff     = x_ext - scaled;
        // In range when all bits above the DATA_W sign bit match it.
        if ((diff[EXT_W-1:DATA_W-1] == '0) || (diff[EXT_W-1:DATA_W-1] == '1)) begin
            y = diff[DATA_W-1:0];
        end else if (diff[EXT_W-1]) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lpc_autocorr.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_autocorr
//  Purpose  : Frame autocorrelation engine for the LPC encoder front end.
//             Accumulates R[k] = sum x[n]*x[n-k], k = 0..ORDER, over a
//             programmable frame with a single shared multiplier, and
//             exposes the committed result bank on an Avalon-MM slave.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-low reset
//             bus        - lpc_autocorr_if.slave (x, v, Avalon-MM slave)
//             frame_done - one-cycle pulse when a result bank is committed
//             busy       - high while the MAC sequence runs
//  Config   : LPC_AUTOCORR_PREEMPH_EN - inserts lpc_preemph in front of the
//             delay line; undefined means samples are used unfiltered.
//  Revision : 1.0 - initial release
// ============================================================================
module lpc_autocorr
    import lpc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ORDER     = 10,
    parameter int MAX_FRAME = 1024,
    parameter int ACC_W     = 42
) (
    input  logic          clk,
    input  logic          rst,
    lpc_autocorr_if.slave bus,
    output logic          frame_done,
    output logic          busy
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int LEN_W  = $clog2(MAX_FRAME + 1);
    localparam int J_W    = $clog2(ORDER + 1);
    localparam int RES_W  = SLICES * 16;

    localparam logic [J_W-1:0]   LAST_TAP     = J_W'(ORDER);
    localparam logic [16:0]      MAX_FRAME_17 = 17'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_RESET    = LEN_W'(FRAME_LEN_RESET);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state;
    state_t                   state_nxt;
    logic [J_W-1:0]           mac_j;
    logic signed [DATA_W-1:0] delay  [0:ORDER];
    logic signed [ACC_W-1:0]  acc    [0:ORDER];
    logic signed [ACC_W-1:0]  result [0:ORDER];
    logic [LEN_W-1:0]         frame_cnt;
    logic [LEN_W-1:0]         len_shadow;
    logic [LEN_W-1:0]         frame_len;
    logic                     enable;
    logic                     ready;
    logic                     overrun;
    logic [15:0]              readdata_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                     accept;
    logic                     drop;
    logic                     commit;
    logic                     clear_frame;
    logic                     last_tap;
    logic                     frame_last;
    logic                     len_wr;
    logic                     ctrl_wr;
    logic                     ctrl_rd;
    logic                     enable_rise;
    logic                     len_valid;
    logic signed [DATA_W-1:0] sample_y;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;

    assign accept      = (state == ST_IDLE) && bus.v && enable;
    assign drop        = bus.v && (state != ST_IDLE);
    assign commit      = (state == ST_COMMIT);
    // A disabled engine sitting in IDLE abandons any partial frame.
    assign clear_frame = commit || ((state == ST_IDLE) && !enable);
    assign last_tap    = (mac_j == LAST_TAP);
    assign frame_last  = ((frame_cnt + LEN_W'(1)) == len_shadow);

    assign len_wr      = bus.write && (bus.address == ADDR_FRAME_LEN);
    assign ctrl_wr     = bus.write && (bus.address == ADDR_CTRL);
    assign ctrl_rd     = bus.read  && (bus.address == ADDR_CTRL);
    assign enable_rise = ctrl_wr && bus.writedata[CTRL_ENABLE_BIT] && !enable;
    assign len_valid   = (bus.writedata != 16'd0) && ({1'b0, bus.writedata} <= MAX_FRAME_17);

`ifdef LPC_AUTOCORR_PREEMPH_EN
    lpc_preemph #(
        .DATA_W (DATA_W)
    ) u_preemph (
        .clk  (clk),
        .rst  (rst),
        .clr  (!enable),
        .load (accept),
        .x    (bus.x),
        .y    (sample_y)
    );
`else
    assign sample_y = bus.x;
`endif

    // Shared multiplier: newest sample times tap j of the delay line.
    assign product     = PROD_W'(delay[0]) * PROD_W'(delay[mac_j]);
    assign product_ext = ACC_W'(product);

    // ------------------------------------------------------------------
    // MAC sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                busy = 1'b1;
                if (last_tap) begin
                    state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                state_nxt = frame_last ? ST_COMMIT : ST_IDLE;
            end
            ST_COMMIT: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Delay line, accumulators and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= ORDER; k++) begin
                delay[k] <= '0;
                acc[k]   <= '0;
            end
            frame_cnt <= '0;
            mac_j     <= '0;
        end else begin
            if (clear_frame) begin
                // Zeroed delay line keeps lag terms from crossing frames.
                for (int k = 0; k <= ORDER; k++) begin
                    delay[k] <= '0;
                    acc[k]   <= '0;
                end
                frame_cnt <= '0;
            end else if (accept) begin
                delay[0] <= sample_y;
                for (int k = 1; k <= ORDER; k++) begin
                    delay[k] <= delay[k-1];
                end
            end

            if (state == ST_MAC) begin
                acc[mac_j] <= acc[mac_j] + product_ext;
                mac_j      <= last_tap ? '0 : mac_j + 1'b1;
            end else begin
                mac_j <= '0;
            end

            if ((state == ST_CHK) && !frame_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Result bank survives aborts; only a commit replaces it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= ORDER; k++) begin
                result[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k <= ORDER; k++) begin
                result[k] <= acc[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_len  <= LEN_RESET;
            len_shadow <= LEN_RESET;
            enable     <= 1'b0;
            ready      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (len_wr && len_valid) begin
                frame_len <= bus.writedata[LEN_W-1:0];
            end
            if (ctrl_wr) begin
                enable <= bus.writedata[CTRL_ENABLE_BIT];
            end
            // A new length only applies from the next frame start.
            if (commit || enable_rise) begin
                len_shadow <= frame_len;
            end
            // Setting wins over the read-to-clear.
            if (commit) begin
                ready <= 1'b1;
            end else if (ctrl_rd) begin
                ready <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ctrl_wr && bus.writedata[CTRL_OVERRUN_BIT]) begin
                overrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [15:0]              res_off;
    logic [13:0]              res_k;
    logic [1:0]               res_s;
    logic                     res_hit;
    logic signed [ACC_W-1:0]  res_sel;
    logic signed [RES_W-1:0]  res_wide;
    logic [15:0]              rd_value;

    always_comb begin
        res_off = bus.address - ADDR_RESULT_BASE;
        res_k   = res_off[15:2];
        res_s   = res_off[1:0];
        res_hit = (bus.address >= ADDR_RESULT_BASE) &&
                  (res_k <= 14'(ORDER)) && (res_s < 2'(SLICES));
        res_sel = '0;
        for (int k = 0; k <= ORDER; k++) begin
            if (res_k == 14'(k)) begin
                res_sel = result[k];
            end
        end
        res_wide = RES_W'(res_sel);
        rd_value = '0;
        if (bus.address == ADDR_FRAME_LEN) begin
            rd_value = 16'(frame_len);
        end else if (bus.address == ADDR_CTRL) begin
            rd_value = {13'd0, overrun, ready, enable};
        end else if (res_hit) begin
            rd_value = res_wide[{res_s, 4'b0000} +: 16];
        end
    end

    // The result bank updates on the same edge as a commit, so a read
    // colliding with COMMIT naturally returns the pre-commit word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdata_q <= '0;
        end else if (bus.read) begin
            readdata_q <= rd_value;
        end
    end

    assign bus.readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lpc_autocorr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lpc_autocorr
//  Purpose  : Self-checking bench for lpc_autocorr. Directed scenarios plus
//             randomized frames, checked against a frame-level reference
//             model (plain autocorrelation sums over a sample queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lpc_autocorr;
    import lpc_pkg::*;

    localparam int DATA_W    = 16;
    localparam int ORDER     = 10;
    localparam int MAX_FRAME = 1024;
    localparam int ACC_W     = 42;
    localparam int GAP       = ORDER + 6;

    localparam logic [15:0] A_LEN  = 16'h0000;
    localparam logic [15:0] A_CTRL = 16'h0001;
    localparam logic [15:0] A_RES  = 16'h0010;

    logic clk;
    logic rst;
    logic frame_done;
    logic busy;

    lpc_autocorr_if #(.DATA_W(DATA_W)) bus ();

    lpc_autocorr #(
        .DATA_W    (DATA_W),
        .ORDER     (ORDER),
        .MAX_FRAME (MAX_FRAME),
        .ACC_W     (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rst && frame_done) done_cnt++;
    end

    // ---------------- reference model ----------------
    longint ref_r [0:ORDER];
    int     frame_q[$];
    int     ref_prev   = 0;
    int     ref_len    = 240;
    int     ref_shadow = 240;
    int     exp_done   = 0;

`ifdef LPC_AUTOCORR_PREEMPH_EN
    function automatic int preemph_ref(int xv, int pv);
        int t;
        t = xv - ((31 * pv) >>> 5);
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction
`endif

    task automatic model_accept(input int xv);
        int yv;
`ifdef LPC_AUTOCORR_PREEMPH_EN
        yv = preemph_ref(xv, ref_prev);
`else
        yv = xv;
`endif
        ref_prev = xv;
        frame_q.push_back(yv);
        if (frame_q.size() == ref_shadow) begin
            for (int k = 0; k <= ORDER; k++) begin
                ref_r[k] = 0;
                for (int n = k; n < frame_q.size(); n++)
                    ref_r[k] += longint'(frame_q[n]) * longint'(frame_q[n-k]);
            end
            frame_q.delete();
            exp_done++;
            ref_shadow = ref_len;
        end
    endtask

    task automatic model_disable();
        frame_q.delete();
        ref_prev = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- bus helpers (entered and left at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        tick(1);
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.address = a; bus.read = 1'b1;
        tick(1);
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic expect_read(input string tag, input logic [15:0] a, input logic [63:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, 64'(d), exp);
    endtask

    task automatic send_sample(input int xv);
        bus.x = DATA_W'(xv); bus.v = 1'b1;
        tick(1);
        bus.v = 1'b0;
    endtask

    task automatic push(input int xv);
        send_sample(xv);
        model_accept(xv);
        tick(GAP);
    endtask

    task automatic configure(input int len);
        bus_write(A_CTRL, 16'h0000);
        model_disable();
        bus_write(A_LEN, 16'(len));
        ref_len = len;
        bus_write(A_CTRL, 16'h0001);
        ref_shadow = ref_len;
    endtask

    task automatic check_bank(input string tag);
        logic [63:0] w;
        for (int k = 0; k <= ORDER; k++) begin
            w = ref_r[k];
            for (int s = 0; s < SLICES; s++)
                expect_read($sformatf("%s R%0d.s%0d", tag, k, s),
                            A_RES + 16'(4*k + s), 64'(w[16*s +: 16]));
        end
        check({tag, " done count"}, 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [63:0] old_w;
        int          xv;
        int          len;

        for (int k = 0; k <= ORDER; k++) ref_r[k] = 0;
        rst = 1'b0;
        bus.x = '0; bus.v = 1'b0; bus.address = '0;
        bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

        // 1: reset state
        tick(3);
        check("readdata in reset", 64'(bus.readdata), 64'd0);
        check("busy in reset", 64'(busy), 64'd0);
        rst = 1'b1;
        tick(2);
        expect_read("reset FRAME_LEN", A_LEN, 64'd240);
        expect_read("reset CTRL", A_CTRL, 64'd0);
        check("reset frame_done count", 64'(done_cnt), 64'd0);

        // 2: 1,2,3,4 with length 4
        configure(4);
        send_sample(1);
        model_accept(1);
        check("busy during MAC", 64'(busy), 64'd1);
        tick(GAP);
        push(2); push(3); push(4);
        check_bank("t2");
`ifndef LPC_AUTOCORR_PREEMPH_EN
        expect_read("t2 R0=30", A_RES + 16'h0, 64'd30);
        expect_read("t2 R1=20", A_RES + 16'h4, 64'd20);
        expect_read("t2 R2=11", A_RES + 16'h8, 64'd11);
        expect_read("t2 R3=4",  A_RES + 16'hC, 64'd4);
`endif
        expect_read("t2 CTRL ready", A_CTRL, 64'h3);
        expect_read("t2 CTRL ready cleared", A_CTRL, 64'h1);

        // 3: full-scale negative samples
        configure(2);
        push(-32768); push(-32768);
        check_bank("t3");
`ifndef LPC_AUTOCORR_PREEMPH_EN
        expect_read("t3 R0.s1", A_RES + 16'h1, 64'h8000);
        expect_read("t3 R1.s1", A_RES + 16'h5, 64'h4000);
`endif

        // 4: overrun from strobes 3 clocks apart
        configure(1);
        send_sample(7);
        model_accept(7);
        tick(2);
        send_sample(9);
        tick(GAP);
        check_bank("t4");
        expect_read("t4 CTRL overrun", A_CTRL, 64'h7);
        bus_write(A_CTRL, 16'h0004);
        model_disable();
        expect_read("t4 CTRL overrun cleared", A_CTRL, 64'h0);

        // 5: frame isolation, and a result read colliding with COMMIT
        configure(2);
        push(1); push(1);
        check_bank("t5a");
        push(5);
        old_w = ref_r[0];
        send_sample(0);
        tick(ORDER + 2);
        check("t5 frame_done in COMMIT", 64'(frame_done), 64'd1);
        expect_read("t5 read at COMMIT pre-commit", A_RES, 64'(old_w[15:0]));
        model_accept(0);
        tick(GAP);
        check_bank("t5b");
`ifndef LPC_AUTOCORR_PREEMPH_EN
        expect_read("t5 R0=25", A_RES + 16'h0, 64'd25);
        expect_read("t5 R1=0",  A_RES + 16'h4, 64'd0);
`endif

        // 6: abort mid-frame, re-enable, full frame
        configure(4);
        push(1); push(2);
        bus_write(A_CTRL, 16'h0000);
        model_disable();
        bus_write(A_CTRL, 16'h0001);
        ref_shadow = ref_len;
        push(1); push(2); push(3); push(4);
        check_bank("t6");
`ifdef LPC_AUTOCORR_PREEMPH_EN
        configure(2);
        push(32); push(32);
        expect_read("t6 preemph R0=1025", A_RES + 16'h0, 64'd1025);
        expect_read("t6 preemph R1=32",   A_RES + 16'h4, 64'd32);
`endif

        // 7: FRAME_LEN written mid-frame applies next frame; READY set vs read
        configure(2);
        push(3);
        bus_write(A_LEN, 16'd3);
        ref_len = 3;
        push(-4);
        check_bank("t7a");
        expect_read("t7 CTRL ready", A_CTRL, 64'h3);
        push(100); push(-200);
        send_sample(300);
        tick(ORDER + 2);
        expect_read("t7 CTRL read at COMMIT", A_CTRL, 64'h1);
        model_accept(300);
        tick(GAP);
        expect_read("t7 CTRL ready kept", A_CTRL, 64'h3);
        check_bank("t7b");

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            len = int'($urandom_range(1, 6));
            configure(len);
            for (int n = 0; n < len; n++) begin
                r = 16'($urandom);
                if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                xv = int'($signed(r));
                push(xv);
            end
            check_bank($sformatf("rand%0d", f));
        end

        // unmapped addresses and FRAME_LEN legality
        expect_read("unmapped 0x02", 16'h0002, 64'd0);
        expect_read("unmapped 0x0F", 16'h000F, 64'd0);
        expect_read("unmapped slice3", 16'h0013, 64'd0);
        expect_read("unmapped past ORDER", A_RES + 16'(4*(ORDER+1)), 64'd0);
        expect_read("unmapped 0xFFFF", 16'hFFFF, 64'd0);
        bus_write(A_LEN, 16'd0);
        expect_read("FRAME_LEN=0 ignored", A_LEN, 64'(ref_len));
        bus_write(A_LEN, 16'(MAX_FRAME + 1));
        expect_read("FRAME_LEN>MAX ignored", A_LEN, 64'(ref_len));
        bus_write(A_LEN, 16'(MAX_FRAME));
        ref_len = MAX_FRAME;
        expect_read("FRAME_LEN=MAX accepted", A_LEN, 64'(ref_len));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
